// File: rtl/countdown_timer_8bit_if.sv
// rtl/countdown_timer_8bit_if.sv - control and display bundle for the countdown timer
interface countdown_timer_8bit_if;
  logic       Load;
  logic [7:0] LoadValue;
  logic       Start;
  logic       Pause;
  logic [7:0] Count;
  logic       Zero;
  logic       Done;
  logic [0:6] HEX0;
  logic [0:6] HEX1;

  // Switch/key side: drives the controls and watches the count and displays.
  modport master (
    output Load, LoadValue, Start, Pause,
    input  Count, Zero, Done, HEX0, HEX1
  );

  // Timer side.
  modport slave (
    input  Load, LoadValue, Start, Pause,
    output Count, Zero, Done, HEX0, HEX1
  );
endinterface

// File: rtl/countdown_timer_8bit.sv
// rtl/countdown_timer_8bit.sv - loadable prescaled 8-bit down counter with expiry pulse; COUNTDOWN_AUTO_RELOAD_EN enables auto-reload
module countdown_timer_8bit #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic                       Clock,
  input  logic                       Reset,
  countdown_timer_8bit_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  state_t      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  rld_q,   rld_d;
  logic [15:0] pre_q,   pre_d;
  logic        done_q,  done_d;

  // Active-low seven-segment pattern, segment a at index 0 through g at index 6.
  function automatic logic [0:6] hex_decoder(input logic [3:0] v);
    logic [0:6] seg;
    case (v)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  // Next-state logic: Load overrides everything, then the per-state run/pause rules.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rld_d   = rld_q;
    pre_d   = pre_q;
    done_d  = 1'b0;

    if (bus.Load) begin
      count_d = bus.LoadValue;
      rld_d   = bus.LoadValue;
      pre_d   = 16'd0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.Pause && bus.Start && count_q != 8'd0) begin
            state_d = RUN;
            pre_d   = 16'd0;
          end
        end
        RUN: begin
          if (bus.Pause) begin
            state_d = PAUSE;
          end else if (pre_q == PRE_MAX) begin
            pre_d = 16'd0;
            if (count_q != 8'd0) begin
              count_d = count_q - 8'd1;
            end
            if (count_q <= 8'd1) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            pre_d = pre_q + 16'd1;
          end
        end
        PAUSE: begin
          // pre is kept so the interrupted period resumes where it left off.
          if (!bus.Pause && bus.Start) begin
            state_d = RUN;
          end
        end
        default: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          // A zero reload value would expire immediately, so stay put.
          if (rld_q != 8'd0) begin
            count_d = rld_q;
            pre_d   = 16'd0;
            state_d = bus.Pause ? PAUSE : RUN;
          end
`else
          state_d = DONE;
`endif
        end
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      count_q <= 8'd0;
      rld_q   <= 8'd0;
      pre_q   <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rld_q   <= rld_d;
      pre_q   <= pre_d;
      done_q  <= done_d;
    end
  end

  assign bus.Count = count_q;
  assign bus.Done  = done_q;
  assign bus.Zero  = (count_q == 8'd0);
  assign bus.HEX0  = hex_decoder(count_q[3:0]);
  assign bus.HEX1  = hex_decoder(count_q[7:4]);

endmodule

// File: tb/tb_countdown_timer_8bit.sv
// tb/tb_countdown_timer_8bit.sv - directed self-checking bench for countdown_timer_8bit
module tb_countdown_timer_8bit;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  countdown_timer_8bit_if bus  ();
  countdown_timer_8bit_if bus1 ();

  countdown_timer_8bit #(.PRESCALE(4)) dut  (.Clock(Clock), .Reset(Reset), .bus(bus));
  countdown_timer_8bit #(.PRESCALE(1)) dut1 (.Clock(Clock), .Reset(Reset), .bus(bus1));

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.Load = 1'b0;  bus.LoadValue = 8'h00;  bus.Start = 1'b0;  bus.Pause = 1'b0;
    bus1.Load = 1'b0; bus1.LoadValue = 8'h00; bus1.Start = 1'b0; bus1.Pause = 1'b0;

    step(); step();
    Reset = 1'b0;
    step();
    chk("rst_count", bus.Count, 8'h00);
    chk("rst_zero",  {7'd0, bus.Zero}, 8'h01);
    chk("rst_done",  {7'd0, bus.Done}, 8'h00);
    chk("rst_hex0",  {1'b0, bus.HEX0}, 8'b00000001);
    chk("rst_hex1",  {1'b0, bus.HEX1}, 8'b00000001);

    // Start with a zero count does nothing.
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("start0_count", bus.Count, 8'h00);
      chk("start0_done",  {7'd0, bus.Done}, 8'h00);
    end

    // Load 3, one-cycle Start, count 3,2,1,0 at 4-cycle intervals.
    bus.Load = 1'b1; bus.LoadValue = 8'h03;
    step();
    bus.Load = 1'b0;
    chk("ld3_count", bus.Count, 8'h03);
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    chk("e0_count", bus.Count, 8'h03);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("run3_count", bus.Count, 8'(3 - k / 4));
      chk("run3_done",  {7'd0, bus.Done}, (k == 12) ? 8'h01 : 8'h00);
    end
    chk("run3_zero", {7'd0, bus.Zero}, 8'h01);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
    bus.Start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("done_hold_count", bus.Count, 8'h00);
      chk("done_hold_done",  {7'd0, bus.Done}, 8'h00);
    end
    bus.Start = 1'b0;
`else
    step();
    chk("reload_count", bus.Count, 8'h03);
    chk("reload_done",  {7'd0, bus.Done}, 8'h00);
`endif

    // Load 0x12, run, pause after 6 cycles; pre must be retained.
    bus.Load = 1'b1; bus.LoadValue = 8'h12;
    step();
    bus.Load = 1'b0;
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("p_run_count", bus.Count, (k >= 4) ? 8'h11 : 8'h12);
    end
    bus.Pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("p_hold_count", bus.Count, 8'h11);
    end
    bus.Pause = 1'b0; bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    chk("p_resume0", bus.Count, 8'h11);
    step();
    chk("p_resume1", bus.Count, 8'h11);
    step();
    chk("p_resume2", bus.Count, 8'h10);

    // Pause and Start together in RUN: stays paused.
    bus.Pause = 1'b1; bus.Start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("ps_hold_count", bus.Count, 8'h10);
    end
    bus.Pause = 1'b0;
    step();
    bus.Start = 1'b0;
    chk("ps_resume0", bus.Count, 8'h10);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("ps_resume_count", bus.Count, (k == 4) ? 8'h0F : 8'h10);
    end

    // Mid-RUN load of 0xA5 aborts the run and waits for Start.
    bus.Load = 1'b1; bus.LoadValue = 8'hA5;
    step();
    bus.Load = 1'b0;
    chk("a5_count", bus.Count, 8'hA5);
    chk("a5_hex1",  {1'b0, bus.HEX1}, 8'b00001000);
    chk("a5_hex0",  {1'b0, bus.HEX0}, 8'b00100100);
    chk("a5_zero",  {7'd0, bus.Zero}, 8'h00);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("a5_idle_count", bus.Count, 8'hA5);
    end

    // PRESCALE=1 instance: decrement every cycle from 2.
    bus1.Load = 1'b1; bus1.LoadValue = 8'h02;
    step();
    bus1.Load = 1'b0;
    bus1.Start = 1'b1;
    step();
    bus1.Start = 1'b0;
    chk("p1_e0_count", bus1.Count, 8'h02);
    for (int k = 1; k <= 9; k++) begin
      step();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      chk("p1_count", bus1.Count, (k % 3 == 0) ? 8'h02 : ((k % 3 == 1) ? 8'h01 : 8'h00));
      chk("p1_done",  {7'd0, bus1.Done}, (k % 3 == 2) ? 8'h01 : 8'h00);
`else
      chk("p1_count", bus1.Count, (k == 1) ? 8'h01 : 8'h00);
      chk("p1_done",  {7'd0, bus1.Done}, (k == 2) ? 8'h01 : 8'h00);
`endif
    end

    // Reset mid-run returns to the cleared state.
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("rst2_count", bus.Count, 8'h00);
    chk("rst2_zero",  {7'd0, bus.Zero}, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/countdown_timer_8bit.md
# countdown_timer_8bit

Loadable 8-bit down counter: the count-down counterpart to the lab's T-flip-flop up counter. A value is loaded from switches, counts down to zero at a prescaled rate under a small run/pause FSM, and signals expiry. The count drives two seven-segment displays through the existing `hex_decoder`. It sits between board switches/keys and HEX0/HEX1 as a standalone lab top-level or sub-block.

## Interface
- `PRESCALE`, default 4: Clock cycles per decrement; legal range 1..65535.
- `Clock` input 1: single clock; all state updates on the rising edge.
- `Reset` input 1: synchronous, active-high reset.
- `Load` input 1: level; copies `LoadValue` into the count and reload registers.
- `LoadValue` input 8: value to load.
- `Start` input 1: level; starts from IDLE or resumes from PAUSE.
- `Pause` input 1: level; suspends counting.
- `Count` output 8: current count, registered.
- `Zero` output 1: combinational, `Count == 0`.
- `Done` output 1: registered one-cycle expiry pulse.
- `HEX0` output [0:6]: `hex_decoder` of `Count[3:0]`, active-low segments.
- `HEX1` output [0:6]: `hex_decoder` of `Count[7:4]`, active-low segments.

## Operation
- State is one of IDLE, RUN, PAUSE, DONE. Prescaler `pre` is 16 bits. `rld` (8 bits) holds the last loaded value.
- Priority each edge: Reset > Load > Pause > Start.
- Reset: state IDLE, `Count`=0, `rld`=0, `pre`=0, `Done`=0. Hence `Zero`=1 and HEX shows "00".
- Load, in any state: `Count`=`rld`=`LoadValue`, `pre`=0, state IDLE, `Done`=0.
- IDLE:
  - Start with `Count`≠0: go to RUN with `pre`=0.
  - Start with `Count`=0: ignored.
  - Pause: ignored.
- RUN:
  - Pause: go to PAUSE; `pre` and `Count` hold.
  - Otherwise: if `pre`==PRESCALE-1, set `pre`=0 and `Count`=`Count`-1; else `pre`+1.
  - A decrement from 1 to 0 goes to DONE and sets `Done`=1 on the same edge.
- PAUSE:
  - Start without Pause: back to RUN, keeping `pre`, so no partial period is lost.
  - Pause and Start together: stay in PAUSE.
- DONE: `Count` holds at 0 and Start is ignored. Exit only by Load or Reset, except as noted under Configuration.
- `Done` is high for exactly the one cycle after the expiring edge, then clears. It is never asserted outside that cycle.
- `Count` never wraps below 0.

## Timing
- Start is sampled at edge E0. The first decrement is visible after edge E0+PRESCALE.
- Each subsequent decrement follows PRESCALE cycles later.
- With value N loaded and no pauses:
  - `Count`=0 and `Done`=1 after edge E0+N·PRESCALE.
  - `Done` drops after the next edge.
- With PRESCALE=1, `Count` decrements every cycle in RUN.
- Load or Reset during RUN or PAUSE takes effect on that edge and aborts any pending tick.
- `Zero`, HEX0 and HEX1 are combinational from `Count`, with zero added latency.

## Configuration
- `COUNTDOWN_AUTO_RELOAD_EN` undefined (default):
  - DONE is terminal until Load or Reset.
- `COUNTDOWN_AUTO_RELOAD_EN` defined:
  - On the edge after entering DONE, `Count`=`rld`, `pre`=0, state RUN.
  - The `Done` pulse still fires on every expiry; period = N·PRESCALE+1 cycles.
  - Pause during that DONE cycle goes to PAUSE with `Count`=`rld`.
  - Load or Reset keep priority over auto-reload.
  - If `rld`=0 (reachable only after Reset), the block stays in DONE.

## Test plan
- Reset, PRESCALE=4:
  - Outputs `Count`=0x00, `Zero`=1, `Done`=0, HEX0=HEX1=7'b0000001.
  - Start alone has no effect.
- Load 0x03, then Start for 1 cycle:
  - `Count` reads 3,2,1,0 at 4-cycle intervals.
  - `Done`=1 for exactly 1 cycle, coincident with the first cycle `Count`=0.
  - State DONE holds for 20 more cycles.
- Load 0x12, Start, then Pause after 6 cycles:
  - `Count`=0x11 and holds for 10 cycles.
  - Release Pause and pulse Start: the next decrement comes 2 cycles later (`pre` retained).
- Pause and Start asserted together while in RUN:
  - Goes to PAUSE and stays there while both are held.
- Mid-RUN Load 0xA5, Load asserted for 1 cycle:
  - Immediately `Count`=0xA5, state IDLE, HEX1/HEX0 show "A"/"5".
  - No decrement occurs until Start.
- With `COUNTDOWN_AUTO_RELOAD_EN`, PRESCALE=1, Load 0x02, Start:
  - `Done` pulses every 3 cycles.
  - `Count` sequence is 2,1,0,2,1,0…
